// File: rtl/bus_responder_pkg.sv
// Shared address map, STATUS bit positions and address decode for the cpu-side responder.
package cpu_bus_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] RAM_TOP  = 8'hEF;
  localparam logic [7:0] OUT_DATA = 8'hF0;
  localparam logic [7:0] IN_DATA  = 8'hF1;
  localparam logic [7:0] STATUS   = 8'hF2;
  localparam logic [7:0] TICK     = 8'hF3;

  localparam int ST_OUT_FULL  = 0;
  localparam int ST_OUT_EMPTY = 1;
  localparam int ST_IN_FULL   = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_UDR       = 4;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_OUT,
    SEL_IN,
    SEL_STATUS,
    SEL_TICK,
    SEL_RSVD
  } sel_e;

  function automatic sel_e decode(input logic [7:0] a);
    sel_e s;
    if (a <= RAM_TOP) begin
      s = SEL_RAM;
    end else begin
      case (a)
        OUT_DATA: s = SEL_OUT;
        IN_DATA:  s = SEL_IN;
        STATUS:   s = SEL_STATUS;
        TICK:     s = SEL_TICK;
        default:  s = SEL_RSVD;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU access bus plus the output/input byte streams of the responder.
interface bus_responder_if;
  import cpu_bus_pkg::*;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              rden;
  logic              wren;
  logic [DATA_W-1:0] data_out;

  logic [DATA_W-1:0] port_out;
  logic              port_out_valid;
  logic              port_out_ready;

  logic [DATA_W-1:0] port_in;
  logic              port_in_valid;
  logic              port_in_ready;

  modport master (
    output addr, data_in, rden, wren, port_out_ready, port_in, port_in_valid,
    input  data_out, port_out, port_out_valid, port_in_ready
  );

  modport slave (
    input  addr, data_in, rden, wren, port_out_ready, port_in, port_in_valid,
    output data_out, port_out, port_out_valid, port_in_ready
  );
endinterface

// File: rtl/bus_responder_out_fifo.sv
// Power-of-two output FIFO; a push into a full FIFO is kept only if a pop frees a slot.
module out_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o,
  output logic              overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign overflow_o = push_i && full_o && !do_pop;
  // Empty FIFO presents 0x00 rather than a stale slot.
  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped responder: 240-byte RAM, output FIFO, one-byte input latch, STATUS and TICK.
module bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  bus_responder_if.slave bus
);

  logic [DATA_W-1:0] ram_q [240];

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              in_full_q, in_full_d;
  logic              ovf_q, ovf_d;
  logic              udr_q, udr_d;
  logic [DATA_W-1:0] tick_q, tick_d;

  sel_e              sel;
  logic              rd_req, wr_req;
  logic              fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty, fifo_ovf;
  logic [DATA_W-1:0] fifo_head;
  logic              capture, in_rd;
  logic [DATA_W-1:0] rd_val, status_val;

  assign sel    = decode(bus.addr);
  // A simultaneous read and write is treated as a write only.
  assign rd_req = bus.rden && !bus.wren;
  assign wr_req = bus.wren;

  assign fifo_push = wr_req && (sel == SEL_OUT);
  assign fifo_pop  = !fifo_empty && bus.port_out_ready;

  out_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .pop_i      (fifo_pop),
    .din_i      (bus.data_in),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head),
    .overflow_o (fifo_ovf)
  );

  assign status_val = {3'b000, udr_q, ovf_q, in_full_q, fifo_empty, fifo_full};
  assign capture    = bus.port_in_valid && !in_full_q;
  assign in_rd      = rd_req && (sel == SEL_IN);

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RAM:    rd_val = ram_q[bus.addr];
      SEL_IN:     rd_val = in_data_q;
      SEL_STATUS: rd_val = status_val;
      SEL_TICK:   rd_val = tick_q;
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    data_out_d = rd_req ? rd_val : data_out_q;
    in_data_d  = capture ? bus.port_in : in_data_q;

    in_full_d = in_full_q;
    if (capture)    in_full_d = 1'b1;
    else if (in_rd) in_full_d = 1'b0;

    // Clears come first so that a same-cycle set takes priority.
    ovf_d = ovf_q;
    if (wr_req && (sel == SEL_STATUS) && bus.data_in[ST_OVF]) ovf_d = 1'b0;
    if (fifo_ovf) ovf_d = 1'b1;

    udr_d = udr_q;
    if (wr_req && (sel == SEL_STATUS) && bus.data_in[ST_UDR]) udr_d = 1'b0;
    if (in_rd && !in_full_q) udr_d = 1'b1;

    tick_d = (wr_req && (sel == SEL_TICK)) ? bus.data_in : tick_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      in_data_q  <= '0;
      in_full_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udr_q      <= 1'b0;
      tick_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      in_data_q  <= in_data_d;
      in_full_q  <= in_full_d;
      ovf_q      <= ovf_d;
      udr_q      <= udr_d;
      tick_q     <= tick_d;
    end
  end

  // RAM keeps its contents across reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_req && (sel == SEL_RAM)) ram_q[bus.addr] <= bus.data_in;
  end

  assign bus.data_out       = data_out_q;
  assign bus.port_out       = fifo_head;
  assign bus.port_out_valid = !fifo_empty;
  assign bus.port_in_ready  = !in_full_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: hand-computed expectations checked by immediate assertions.
module tb_bus_responder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bus_responder_if bif ();

  bus_responder #(.OUT_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bif.addr = a; bif.data_in = d; bif.wren = 1'b1; bif.rden = 1'b0;
    cyc();
    bif.wren = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    bif.addr = a; bif.rden = 1'b1; bif.wren = 1'b0;
    cyc();
    bif.rden = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bif.addr = 8'h00; bif.data_in = 8'h00; bif.rden = 1'b0; bif.wren = 1'b0;
    bif.port_out_ready = 1'b0; bif.port_in = 8'h00; bif.port_in_valid = 1'b0;
    cyc();
    cyc();
    chk("rst_data_out", bif.data_out, 8'h00);
    chk("rst_out_valid", {7'd0, bif.port_out_valid}, 8'h00);
    chk("rst_port_out", bif.port_out, 8'h00);
    chk("rst_in_ready", {7'd0, bif.port_in_ready}, 8'h01);
    rst = 1'b0;

    rd(8'hF3); chk("rst_tick", bif.data_out, 8'h00);
    rd(8'hF2); chk("rst_status", bif.data_out, 8'h02);

    wr(8'h10, 8'h5A);
    rd(8'h10); chk("ram_rd_10", bif.data_out, 8'h5A);

    // Read and write together: write happens, data_out holds.
    bif.addr = 8'h20; bif.data_in = 8'h33; bif.rden = 1'b1; bif.wren = 1'b1;
    cyc();
    bif.rden = 1'b0; bif.wren = 1'b0;
    chk("rdwr_hold", bif.data_out, 8'h5A);
    rd(8'h20); chk("ram_rd_20", bif.data_out, 8'h33);

    wr(8'hF8, 8'hAA);
    rd(8'hF8); chk("rsvd_rd", bif.data_out, 8'h00);
    rd(8'h10); chk("ram_rd_10b", bif.data_out, 8'h5A);
    rd(8'hF0); chk("outdata_rd", bif.data_out, 8'h00);

    // Overfill the FIFO with the sink stalled.
    for (int i = 1; i <= 5; i++) wr(8'hF0, 8'(i));
    rd(8'hF2); chk("status_full_ovf", bif.data_out, 8'h09);
    chk("head_01", bif.port_out, 8'h01);
    chk("valid_full", {7'd0, bif.port_out_valid}, 8'h01);
    bif.port_out_ready = 1'b1;
    chk("drain_01", bif.port_out, 8'h01); cyc();
    chk("drain_02", bif.port_out, 8'h02); cyc();
    chk("drain_03", bif.port_out, 8'h03); cyc();
    chk("drain_04", bif.port_out, 8'h04); cyc();
    chk("drain_valid0", {7'd0, bif.port_out_valid}, 8'h00);
    chk("drain_out0", bif.port_out, 8'h00);
    bif.port_out_ready = 1'b0;
    wr(8'hF2, 8'h08);
    rd(8'hF2); chk("ovf_cleared", bif.data_out, 8'h02);

    // Push while full with a simultaneous pop.
    wr(8'hF0, 8'hA1); wr(8'hF0, 8'hA2); wr(8'hF0, 8'hA3); wr(8'hF0, 8'hA4);
    rd(8'hF2); chk("status_full", bif.data_out, 8'h01);
    bif.port_out_ready = 1'b1;
    wr(8'hF0, 8'h77);
    bif.port_out_ready = 1'b0;
    chk("pushpop_head", bif.port_out, 8'hA2);
    rd(8'hF2); chk("pushpop_no_ovf", bif.data_out, 8'h01);
    bif.port_out_ready = 1'b1;
    chk("seq_a2", bif.port_out, 8'hA2); cyc();
    chk("seq_a3", bif.port_out, 8'hA3); cyc();
    chk("seq_a4", bif.port_out, 8'hA4); cyc();
    chk("seq_77", bif.port_out, 8'h77); cyc();
    chk("seq_empty", {7'd0, bif.port_out_valid}, 8'h00);
    bif.port_out_ready = 1'b0;

    // Input latch capture, rejection while full, read-out and underrun.
    bif.port_in = 8'h3C; bif.port_in_valid = 1'b1;
    cyc();
    bif.port_in_valid = 1'b0;
    chk("in_ready_low", {7'd0, bif.port_in_ready}, 8'h00);
    rd(8'hF2); chk("status_in_full", bif.data_out, 8'h06);
    bif.port_in = 8'h55; bif.port_in_valid = 1'b1;
    cyc();
    bif.port_in_valid = 1'b0;
    rd(8'hF1); chk("in_rd_3c", bif.data_out, 8'h3C);
    chk("in_ready_back", {7'd0, bif.port_in_ready}, 8'h01);
    rd(8'hF1); chk("in_rd_stale", bif.data_out, 8'h3C);
    rd(8'hF2); chk("status_udr", bif.data_out, 8'h12);
    wr(8'hF2, 8'h10);
    rd(8'hF2); chk("udr_cleared", bif.data_out, 8'h02);

    // TICK load then consecutive reads across the wrap.
    wr(8'hF3, 8'hFE);
    rd(8'hF3); chk("tick_fe", bif.data_out, 8'hFE);
    rd(8'hF3); chk("tick_ff", bif.data_out, 8'hFF);
    rd(8'hF3); chk("tick_00", bif.data_out, 8'h00);

    // Reset mid-transfer with competing accesses and handshakes.
    wr(8'hF0, 8'h11); wr(8'hF0, 8'h22); wr(8'hF0, 8'h33);
    bif.port_in = 8'h44; bif.port_in_valid = 1'b1;
    cyc();
    bif.port_in_valid = 1'b0;
    chk("pre_rst_valid", {7'd0, bif.port_out_valid}, 8'h01);
    chk("pre_rst_in_ready", {7'd0, bif.port_in_ready}, 8'h00);
    rst = 1'b1;
    bif.addr = 8'h10; bif.data_in = 8'h99; bif.wren = 1'b1;
    bif.port_in_valid = 1'b1; bif.port_out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    bif.wren = 1'b0; bif.port_in_valid = 1'b0; bif.port_out_ready = 1'b0;
    chk("mid_rst_valid", {7'd0, bif.port_out_valid}, 8'h00);
    chk("mid_rst_port_out", bif.port_out, 8'h00);
    chk("mid_rst_in_ready", {7'd0, bif.port_in_ready}, 8'h01);
    chk("mid_rst_data_out", bif.data_out, 8'h00);
    rd(8'hF2); chk("mid_rst_status", bif.data_out, 8'h02);
    rd(8'h10); chk("ram_kept", bif.data_out, 8'h5A);
    rd(8'hF1); chk("in_data_reset", bif.data_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
